echo_request_deframer: RTL and testbench

- Upstream neighbour of the EchoRequest portal demux.
- Assembles a stream of 32-bit words from the host portal FIFO into one 128-bit message and presents it on a pipe enq interface.
- Layout matches what the demux decodes: word 0 is the header (method id in [31:16], word count in [15:0]); payload word i occupies bits [32*i+31:32*i].
- Drops malformed messages and counts them.

---
 rtl/echo_request_deframer.sv | 129 ++++++++++++
 tb/tb_echo_request_deframer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/echo_request_deframer.sv
// Assembles 32-bit portal words into one 32*MAX_WORDS-bit EchoRequest message.
// Malformed headers are dropped, their payload is skipped, and a saturating error count is kept.
module echo_request_deframer #(
    parameter int MAX_WORDS   = 4,
    parameter int NUM_METHODS = 3,
    parameter int ERR_WIDTH   = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_enq__ENA,
    input  logic [31:0]            in_enq_v,
    output logic                   in_enq__RDY,
    output logic                   pipe_enq__ENA,
    output logic [32*MAX_WORDS-1:0] pipe_enq_v,
    input  logic                   pipe_enq__RDY,
    output logic [ERR_WIDTH-1:0]   err_count
);
    // state   | meaning
    // IDLE    | waiting for a header word
    // COLLECT | storing payload words of a valid message
    // DISCARD | skipping payload words of a malformed message
    // SEND    | holding the assembled message until downstream takes it
    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, SEND} state_t;

    localparam int          IDXW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
    localparam logic [15:0] NUM_M = 16'(NUM_METHODS);

    state_t                  state_q, state_d;
    logic [32*MAX_WORDS-1:0] buf_q, buf_d;
    logic [15:0]             remaining_q, remaining_d;
    logic [IDXW-1:0]         wr_idx_q, wr_idx_d;
    logic [ERR_WIDTH-1:0]    err_q, err_d;
    logic                    in_rdy_q, in_rdy_d;
    logic                    ena_q, ena_d;

    logic        in_xfer;
    logic [15:0] hdr_len;
    logic [15:0] hdr_id;

    assign in_xfer = in_enq__ENA && in_rdy_q;
    assign hdr_len = in_enq_v[15:0];
    assign hdr_id  = in_enq_v[31:16];

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        remaining_d = remaining_q;
        wr_idx_d    = wr_idx_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    if (hdr_len != 16'd0 && hdr_len <= MAX_N && hdr_id < NUM_M) begin
                        buf_d       = '0;
                        buf_d[31:0] = in_enq_v;
                        remaining_d = hdr_len - 16'd1;
                        wr_idx_d    = IDXW'(1);
                        state_d     = (hdr_len == 16'd1) ? SEND : COLLECT;
                    end else begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_WIDTH'(1);
                        end
                        // N==0 would wrap here, but it returns to IDLE so the value is never used
                        remaining_d = hdr_len - 16'd1;
                        state_d     = (hdr_len <= 16'd1) ? IDLE : DISCARD;
                    end
                end
            end
            COLLECT: begin
                if (in_xfer) begin
                    for (int i = 0; i < MAX_WORDS; i++) begin
                        if (wr_idx_q == IDXW'(i)) begin
                            buf_d[32*i +: 32] = in_enq_v;
                        end
                    end
                    wr_idx_d    = wr_idx_q + IDXW'(1);
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = SEND;
                    end
                end
            end
            DISCARD: begin
                if (in_xfer) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            SEND: begin
                if (pipe_enq__RDY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next state, so RDY never feeds through
        in_rdy_d = (state_d != SEND);
        ena_d    = (state_d == SEND);
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            remaining_q <= '0;
            wr_idx_q    <= '0;
            err_q       <= '0;
            in_rdy_q    <= 1'b1;
            ena_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            remaining_q <= remaining_d;
            wr_idx_q    <= wr_idx_d;
            err_q       <= err_d;
            in_rdy_q    <= in_rdy_d;
            ena_q       <= ena_d;
        end
    end

    assign in_enq__RDY   = in_rdy_q;
    assign pipe_enq__ENA = ena_q;
    assign pipe_enq_v    = buf_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_echo_request_deframer.sv
// Directed bench for echo_request_deframer: hand-computed messages, stalls, gaps, drops and resets.
module tb_echo_request_deframer;
    logic         CLK = 1'b0;
    logic         nRST;
    logic         in_ena;
    logic [31:0]  in_v;
    logic         in_rdy;
    logic         pipe_ena;
    logic [127:0] pipe_v;
    logic         pipe_rdy;
    logic [7:0]   err_count;

    int checks = 0;
    int passes = 0;
    int xfers  = 0;
    int base;
    logic [127:0] last_msg = '0;

    echo_request_deframer dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .in_enq__ENA   (in_ena),
        .in_enq_v      (in_v),
        .in_enq__RDY   (in_rdy),
        .pipe_enq__ENA (pipe_ena),
        .pipe_enq_v    (pipe_v),
        .pipe_enq__RDY (pipe_rdy),
        .err_count     (err_count)
    );

    always #5 CLK = ~CLK;

    // Records every downstream transfer as seen at the clock edge
    always @(posedge CLK) begin
        if (pipe_ena && pipe_rdy) begin
            xfers    <= xfers + 1;
            last_msg <= pipe_v;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        in_ena = 1'b1;
        in_v   = w;
        tick();
        in_ena = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        nRST = 1'b1;
        tick();
        tick();
        nRST = 1'b0;
        tick();
    endtask

    initial begin
        nRST     = 1'b1;
        in_ena   = 1'b0;
        in_v     = '0;
        pipe_rdy = 1'b1;
        do_reset();
        chk("reset_in_rdy", 128'(in_rdy), 128'(1));
        chk("reset_pipe_ena", 128'(pipe_ena), 128'(0));
        chk("reset_pipe_v", pipe_v, 128'(0));
        chk("reset_err", 128'(err_count), 128'(0));

        // say, back-to-back words, downstream always ready
        send_word(32'h0001_0002);
        chk("say_hdr_no_ena", 128'(pipe_ena), 128'(0));
        send_word(32'h1234_5678);
        chk("say_ena", 128'(pipe_ena), 128'(1));
        chk("say_in_rdy_low", 128'(in_rdy), 128'(0));
        chk("say_v", pipe_v, {64'h0, 64'h12345678_00010002});
        tick();
        chk("say_one_xfer", 128'(xfers), 128'(1));
        chk("say_ena_drop", 128'(pipe_ena), 128'(0));
        chk("say_in_rdy_back", 128'(in_rdy), 128'(1));

        // single-word message right after, exercises buffer clear
        send_word(32'h0000_0001);
        chk("n1_ena", 128'(pipe_ena), 128'(1));
        chk("n1_v", pipe_v, {96'h0, 32'h0000_0001});
        tick();
        chk("n1_xfer", 128'(xfers), 128'(2));
        chk("n1_last", last_msg, {96'h0, 32'h0000_0001});

        // full-length message (N == MAX_WORDS)
        send_word(32'h0002_0004);
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        send_word(32'hCCCC_0003);
        chk("n4_v", pipe_v, 128'hCCCC0003_BBBB0002_AAAA0001_00020004);
        tick();
        chk("n4_xfer", 128'(xfers), 128'(3));

        // say2 with downstream stall; upstream keeps offering a word it must not take
        pipe_rdy = 1'b0;
        send_word(32'h0000_0002);
        send_word(32'hBEEF_CAFE);
        in_ena = 1'b1;
        in_v   = 32'hDEAD_DEAD;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ena", 128'(pipe_ena), 128'(1));
            chk("stall_in_rdy", 128'(in_rdy), 128'(0));
            chk("stall_v", pipe_v, {64'h0, 64'hBEEFCAFE_00000002});
            tick();
        end
        in_ena = 1'b0;
        chk("stall_no_xfer", 128'(xfers), 128'(3));
        pipe_rdy = 1'b1;
        tick();
        chk("stall_one_xfer", 128'(xfers), 128'(4));
        chk("stall_last", last_msg, {64'h0, 64'hBEEFCAFE_00000002});
        chk("stall_idle_rdy", 128'(in_rdy), 128'(1));

        // setLeds with input gaps
        send_word(32'h0002_0002);
        tick();
        tick();
        tick();
        chk("gap_no_ena", 128'(pipe_ena), 128'(0));
        send_word(32'h0000_00A5);
        chk("leds_byte", 128'(pipe_v[39:32]), 128'(8'hA5));
        chk("leds_id", 128'(pipe_v[31:16]), 128'(16'h0002));
        chk("leds_v", pipe_v, {64'h0, 64'h000000A5_00020002});
        tick();
        tick();
        tick();
        chk("leds_once", 128'(xfers), 128'(5));

        // bad method id: its two payload words are dropped, then a clean say
        send_word(32'h0005_0003);
        chk("badid_err", 128'(err_count), 128'(1));
        send_word(32'h0001_0002);
        send_word(32'h0001_0002);
        chk("badid_discard_no_ena", 128'(pipe_ena), 128'(0));
        send_word(32'h0001_0002);
        send_word(32'h1111_2222);
        chk("badid_say_v", pipe_v, {64'h0, 64'h11112222_00010002});
        tick();
        chk("badid_xfer", 128'(xfers), 128'(6));
        chk("badid_err_hold", 128'(err_count), 128'(1));

        // oversize then zero length, from a fresh reset
        do_reset();
        chk("rst_clears_err", 128'(err_count), 128'(0));
        base = xfers;
        send_word(32'h0001_0009);
        for (int i = 0; i < 8; i++) begin
            send_word(32'h0001_0001 + 32'(i));
        end
        send_word(32'h0000_0000);
        tick();
        chk("oversize_err", 128'(err_count), 128'(2));
        chk("oversize_no_xfer", 128'(xfers - base), 128'(0));
        chk("oversize_in_rdy", 128'(in_rdy), 128'(1));
        for (int i = 0; i < 248; i++) begin
            send_word(32'h0003_0000);
        end
        chk("err_250", 128'(err_count), 128'(250));
        for (int i = 0; i < 52; i++) begin
            send_word(32'h0003_0000);
        end
        chk("err_saturate", 128'(err_count), 128'(255));
        chk("sat_no_xfer", 128'(xfers - base), 128'(0));

        // reset in COLLECT aborts the partial message silently
        do_reset();
        base = xfers;
        send_word(32'h0001_0003);
        send_word(32'h5555_5555);
        nRST = 1'b1;
        #2;
        chk("abort_ena", 128'(pipe_ena), 128'(0));
        chk("abort_v", pipe_v, 128'(0));
        tick();
        nRST = 1'b0;
        tick();
        chk("abort_err", 128'(err_count), 128'(0));
        chk("abort_in_rdy", 128'(in_rdy), 128'(1));
        send_word(32'h0001_0002);
        send_word(32'hCAFE_F00D);
        chk("post_abort_v", pipe_v, {64'h0, 64'hCAFEF00D_00010002});
        tick();
        chk("post_abort_xfer", 128'(xfers - base), 128'(1));
        chk("post_abort_err", 128'(err_count), 128'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
